mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-strobe width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive D grants tolerated while I waits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  1  fetch-side read request; held until i_gnt.
REQ-007 i_addr  input  ADDR_W  fetch address.
REQ-008 i_gnt  output  1  one-cycle pulse when the fetch request is accepted.
REQ-009 i_rvalid  output  1  one-cycle pulse when i_rdata is valid.
REQ-010 i_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  memory-stage request; held until d_gnt.
REQ-012 d_we  input  1  1=write, 0=read.
REQ-013 d_wstrb  input  DATA_W/8  write byte strobes.
REQ-014 d_addr  input  ADDR_W  data address.
REQ-015 d_wdata  input  DATA_W  write data.
REQ-016 d_gnt  output  1  one-cycle pulse when the data request is accepted.
REQ-017 d_rvalid  output  1  one-cycle completion pulse for reads and writes.
REQ-018 d_rdata  output  DATA_W  data read result; undefined for writes.
REQ-019 mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata  output  1/1/DATA_W/8/ADDR_W/DATA_W  registered unified-memory request, held stable until mem_ack.
REQ-020 mem_ack  input  1  memory completion, valid only while mem_req=1.
REQ-021 mem_rdata  input  DATA_W  read data, valid with mem_ack.

Function
REQ-022 SHALL implement FSM IDLE, BUSY_I, BUSY_D; one transaction outstanding at most.
REQ-023 IDLE: grant pulse combinational in the arbitration cycle; request fields latched into mem_* at that edge; mem_req=1 from the next cycle.
REQ-024 Arbitration SHALL be fixed priority D over I; I granted only when d_req=0, subject to REQ-033.
REQ-025 IDLE, neither request: no grant, stay IDLE, mem_req=0.
REQ-026 BUSY_x: no grants issued; mem_* held constant until mem_ack=1.
REQ-027 On mem_ack in BUSY_x: mem_req deasserts next cycle; x_rvalid pulses next cycle with x_rdata registered from mem_rdata; FSM returns to IDLE.
REQ-028 One IDLE cycle SHALL separate consecutive transactions; minimum request-to-rvalid latency with mem_ack in first mem_req cycle is 3 cycles (gnt at T, mem_req T+1, rvalid T+2 relative edges: gnt cycle, ack cycle, rvalid cycle).
REQ-029 i_rvalid and d_rvalid SHALL never be asserted in the same cycle; grants likewise.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 x_rdata SHALL hold its last value until the next x_rvalid.

Reset
REQ-032 reset asserted: FSM=IDLE, all grants/rvalid/mem_req/mem_we=0, mem_addr/mem_wdata/mem_wstrb/rdata=0, starvation counter=0; an in-flight transaction is dropped with no rvalid, including reset mid-BUSY.

Configuration
REQ-033 With MEM_ARB_STARVE_GUARD_EN defined: counter counts D grants issued while i_req=1, cleared on any I grant or when i_req=0; when counter equals STARVE_MAX, next IDLE arbitration with i_req=1 SHALL grant I regardless of d_req; counter saturates at STARVE_MAX.
REQ-034 Without MEM_ARB_STARVE_GUARD_EN: no counter instantiated; strict D priority, I may starve indefinitely.

Structure
REQ-035 FSM state encoding and owner enum SHALL live in the shared cpu_defs header alongside existing bus width constants.
REQ-036 Starvation counter SHALL be a sub-module arb_starve_ctr, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-037 I-only read: i_req=1, i_addr=0x100, mem_ack on first mem_req cycle, mem_rdata=0x00000013 -> i_gnt one pulse, mem_addr=0x100, i_rvalid one pulse with i_rdata=0x00000013, mem_req=0 after.
REQ-038 Simultaneous i_req and d_req (d_addr=0x2000 read) -> d_gnt first; i_gnt after d_rvalid plus one IDLE cycle.
REQ-039 D write d_addr=0x3000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_ack delayed 5 cycles -> mem_* stable all 5 cycles, d_rvalid one pulse after ack, no i_rvalid.
REQ-040 With guard, STARVE_MAX=4, d_req and i_req both held high -> 4 D grants then 1 I grant, repeating; without guard -> zero I grants over 50 cycles.
REQ-041 Reset asserted in BUSY_D before mem_ack -> mem_req=0 immediately (async), no d_rvalid after release, next request served normally.
REQ-042 Spurious mem_ack in IDLE -> no rvalid, FSM stays IDLE.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs -- shared CPU bus definitions.
// Holds the default bus widths used across the core, plus the state and
// owner encodings of the unified-memory arbiter (mem_arbiter).
package cpu_defs;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  // Arbiter FSM: at most one memory transaction outstanding.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Which requester wins the current arbitration cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } arb_owner_t;

  // State entered after an arbitration cycle won by the given owner.
  function automatic arb_state_t busy_state(input arb_owner_t owner);
    arb_state_t s;
    unique case (owner)
      OWNER_I: s = ARB_BUSY_I;
      OWNER_D: s = ARB_BUSY_D;
      default: s = ARB_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr -- fetch starvation counter for mem_arbiter.
// Counts data-side grants issued while the fetch side is waiting; cleared by
// a fetch grant or whenever the fetch side is not requesting. Saturates at
// STARVE_MAX, at which point 'starved' tells the arbiter to favour fetch.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_req        fetch request pending
//   i_grant      fetch grant issued this cycle
//   d_grant      data grant issued this cycle
//   starved      counter has reached STARVE_MAX
module arb_starve_ctr
  import cpu_defs::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_grant,
  input  logic d_grant,
  output logic starved
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (i_grant || !i_req) begin
      cnt <= '0;
    end else if (d_grant && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (fetch / data) arbiter onto one unified memory bus.
// Fixed priority data over fetch, one transaction outstanding. Grants are
// combinational in the IDLE arbitration cycle; the winning request is
// registered onto mem_* at that edge and held until mem_ack. Completion is
// reported one cycle after mem_ack on the owning side's rvalid/rdata.
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN): after STARVE_MAX
// consecutive data grants while fetch waits, the next arbitration with a
// fetch request grants fetch. Without the macro, data has strict priority.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   i_req/i_addr -> i_gnt             fetch request / accept pulse
//   i_rvalid/i_rdata                  fetch completion and read data
//   d_req/d_we/d_wstrb/d_addr/d_wdata -> d_gnt   data request / accept pulse
//   d_rvalid/d_rdata                  data completion and read data
//   mem_req/mem_we/mem_wstrb/mem_addr/mem_wdata  registered memory request
//   mem_ack/mem_rdata                 memory completion and read data
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned DATA_W     = BUS_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // fetch side
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // data side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // unified memory
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state;
  arb_owner_t owner;
  logic       starved;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .i_grant(i_gnt),
    .d_grant(d_gnt),
    .starved(starved)
  );
`else
  assign starved = 1'b0;
`endif

  // Arbitration only happens in IDLE; a saturated starvation count lets a
  // waiting fetch request jump ahead of data.
  always_comb begin
    owner = OWNER_NONE;
    if (state == ARB_IDLE) begin
      if (i_req && starved) begin
        owner = OWNER_I;
      end else if (d_req) begin
        owner = OWNER_D;
      end else if (i_req) begin
        owner = OWNER_I;
      end
    end
  end

  assign i_gnt = (owner == OWNER_I);
  assign d_gnt = (owner == OWNER_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          // mem_ack is ignored here: mem_req is low in IDLE.
          state   <= busy_state(owner);
          mem_req <= (owner != OWNER_NONE);
          if (owner == OWNER_D) begin
            mem_we    <= d_we;
            mem_wstrb <= d_wstrb;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (owner == OWNER_I) begin
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end
        end
        ARB_BUSY_I: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            i_rvalid <= 1'b1;
            i_rdata  <= mem_rdata;
            state    <= ARB_IDLE;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            d_rvalid <= 1'b1;
            d_rdata  <= mem_rdata;
            state    <= ARB_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
// A behavioural memory answers mem_req after a programmable delay; each
// scenario task drives the two requesters and checks results inline against
// expectations derived from the arbitration rules. Define
// MEM_ARB_STARVE_GUARD_EN for both DUT and bench to cover the guarded build.
module tb_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int          SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [SW-1:0] d_wstrb = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  logic [DW-1:0] mem_img [logic [AW-1:0]];
  int            ack_delay = 0;
  int            wait_cnt  = 0;
  bit            spurious  = 1'b0;
  logic [DW-1:0] wtmp;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (reset) begin
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          wtmp = mem_read(mem_addr);
          for (int b = 0; b < SW; b++)
            if (mem_wstrb[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_img[mem_addr] = wtmp;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_read(mem_addr);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spurious) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Tasks start and end at posedge+1; outputs are sampled at negedge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (8) next_edge();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_fields: addr=%h wdata=%h wstrb=%b expected zeros", mem_addr, mem_wdata, mem_wstrb);
    end
    n_checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h expected 0", i_rdata, d_rdata);
    end
    next_edge();
    reset = 1'b0;
    next_edge();
  endtask

  task automatic test_i_read();
    int gnt_n = 0, rv_n = 0, d_act = 0, req_n = 0, bad = 0, gc = -1, rc = -1;
    mem_img[32'h100] = 32'h0000_0013;
    ack_delay = 0;
    i_req  = 1'b1;
    i_addr = 32'h100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_gnt) begin gnt_n++; gc = c; end
      if (i_rvalid) begin rv_n++; rc = c; end
      if (d_gnt || d_rvalid) d_act++;
      if (mem_req) begin
        req_n++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) bad++;
      end
      next_edge();
      if (gc == c) begin i_req = 1'b0; i_addr = 32'hFFFF_FFF0; end
    end
    n_checks++;
    if (gnt_n != 1 || gc != 0) begin n_fail++; $display("FAIL iread_gnt: count=%0d cycle=%0d expected 1 at 0", gnt_n, gc); end
    n_checks++;
    if (req_n != 1 || bad != 0) begin n_fail++; $display("FAIL iread_mem: req_cycles=%0d bad=%0d expected 1/0", req_n, bad); end
    n_checks++;
    if (rv_n != 1 || rc != gc + 2) begin n_fail++; $display("FAIL iread_rvalid: count=%0d cycle=%0d expected 1 at %0d", rv_n, rc, gc + 2); end
    n_checks++;
    if (i_rdata !== 32'h0000_0013) begin n_fail++; $display("FAIL iread_rdata: got %h expected 00000013", i_rdata); end
    n_checks++;
    if (mem_req !== 1'b0 || d_act != 0) begin n_fail++; $display("FAIL iread_after: mem_req=%b d_activity=%0d expected 0/0", mem_req, d_act); end
    drain();
  endtask

  task automatic test_simultaneous();
    int dg = -1, dr = -1, ig = -1, ir = -1, both = 0;
    logic [DW-1:0] exp_d, exp_i;
    exp_d = mem_read(32'h2000);
    exp_i = mem_read(32'h400);
    ack_delay = 0;
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_gnt && d_gnt) both++;
      if (d_gnt && dg < 0) dg = c;
      if (i_gnt && ig < 0) ig = c;
      if (d_rvalid && dr < 0) dr = c;
      if (i_rvalid && ir < 0) ir = c;
      next_edge();
      if (dg == c) d_req = 1'b0;
      if (ig == c) i_req = 1'b0;
    end
    n_checks++;
    if (dg != 0 || both != 0) begin n_fail++; $display("FAIL simul_d_first: d_gnt cycle=%0d both=%0d expected 0/0", dg, both); end
    n_checks++;
    if (dr != 2 || ig != dr) begin n_fail++; $display("FAIL simul_i_after: i_gnt=%0d d_rvalid=%0d expected both 2", ig, dr); end
    n_checks++;
    if (ir != ig + 2) begin n_fail++; $display("FAIL simul_i_rvalid: cycle=%0d expected %0d", ir, ig + 2); end
    n_checks++;
    if (d_rdata !== exp_d || i_rdata !== exp_i) begin
      n_fail++;
      $display("FAIL simul_rdata: d=%h i=%h expected %h %h", d_rdata, i_rdata, exp_d, exp_i);
    end
    drain();
  endtask

  task automatic test_d_write_delayed();
    int req_n = 0, bad = 0, ack_c = -1, rv_c = -1, rv_n = 0, irv = 0, gc = -1;
    ack_delay = 5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_gnt) gc = c;
      if (mem_req) begin
        req_n++;
        if (mem_addr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0011 || mem_we !== 1'b1) bad++;
      end
      if (mem_ack && mem_req) ack_c = c;
      if (d_rvalid) begin rv_n++; rv_c = c; end
      if (i_rvalid) irv++;
      next_edge();
      if (gc == c) begin
        d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'b1100; d_we = 1'b0;
      end
    end
    n_checks++;
    if (req_n != 6 || bad != 0) begin n_fail++; $display("FAIL dwrite_stable: req_cycles=%0d bad=%0d expected 6/0", req_n, bad); end
    n_checks++;
    if (rv_n != 1 || rv_c != ack_c + 1) begin n_fail++; $display("FAIL dwrite_rvalid: count=%0d cycle=%0d expected 1 at %0d", rv_n, rv_c, ack_c + 1); end
    n_checks++;
    if (irv != 0) begin n_fail++; $display("FAIL dwrite_no_irvalid: got %0d expected 0", irv); end
    ack_delay = 0;
    drain();
  endtask

  task automatic test_starvation();
    int s = 0, bad = 0, ig = 0, dg = 0;
    ack_delay = 0;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        // Expected pattern: SMAX data grants, then one fetch grant.
        if (s == SMAX) begin
          if (!i_gnt || d_gnt) bad++;
          s = 0;
        end else begin
          if (!d_gnt || i_gnt) bad++;
          s++;
        end
      end
      if (i_gnt) ig++;
      if (d_gnt) dg++;
      next_edge();
    end
    n_checks++;
    if (bad != 0 || ig < 5 || dg < 20) begin
      n_fail++;
      $display("FAIL starve_pattern: bad=%0d i_grants=%0d d_grants=%0d expected 0 bad, >=5, >=20", bad, ig, dg);
    end
`else
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (i_gnt) ig++;
      if (d_gnt) dg++;
      next_edge();
    end
    n_checks++;
    if (ig != 0 || dg < 20) begin
      n_fail++;
      $display("FAIL strict_priority: i_grants=%0d d_grants=%0d expected 0 and >=20", ig, dg);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid_busy();
    int act = 0, dg = -1, dr = -1;
    logic [DW-1:0] exp_d;
    ack_delay = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
    @(negedge clk);
    n_checks++;
    if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_busy_gnt: got %b expected 1", d_gnt); end
    next_edge();
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: mem_req=%b expected 1", mem_req); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_busy_async: mem_req=%b expected 0", mem_req); end
    next_edge();
    reset = 1'b0;
    ack_delay = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_rvalid || i_rvalid || mem_req) act++;
      next_edge();
    end
    n_checks++;
    if (act != 0) begin n_fail++; $display("FAIL rst_busy_dropped: activity=%0d expected 0", act); end
    exp_d = mem_read(32'h5004);
    d_req = 1'b1; d_addr = 32'h5004;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_gnt && dg < 0) dg = c;
      if (d_rvalid && dr < 0) dr = c;
      next_edge();
      if (dg == c) d_req = 1'b0;
    end
    n_checks++;
    if (dg != 0 || dr != 2 || d_rdata !== exp_d) begin
      n_fail++;
      $display("FAIL rst_busy_next: gnt=%0d rvalid=%0d rdata=%h expected 0,2,%h", dg, dr, d_rdata, exp_d);
    end
    drain();
  endtask

  task automatic test_spurious_ack();
    int act = 0;
    spurious = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid || mem_req || i_gnt || d_gnt) act++;
      next_edge();
    end
    spurious = 1'b0;
    n_checks++;
    if (act != 0) begin n_fail++; $display("FAIL spurious_ack: activity=%0d expected 0", act); end
    i_req = 1'b1; i_addr = 32'h200;
    @(negedge clk);
    n_checks++;
    if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL spurious_still_idle: i_gnt=%b expected 1", i_gnt); end
    next_edge();
    drain();
  endtask

  task automatic test_random();
    bit            out_act = 1'b0, out_d = 1'b0, exp_we = 1'b0, ack_prev = 1'b0;
    bit            seen_i = 1'b0, seen_d = 1'b0, want_i, want_d, gi, gd, rv_ok;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0, exp_wdata = '0, last_i = '0, last_d = '0, got;
    logic [SW-1:0] exp_wstrb = '0;
    int            s = 0, age = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      gi = i_gnt;
      gd = d_gnt;
      // completion reported exactly one cycle after mem_ack
      if (ack_prev) begin
        rv_ok = out_d ? (d_rvalid === 1'b1 && i_rvalid === 1'b0) : (i_rvalid === 1'b1 && d_rvalid === 1'b0);
        n_checks++;
        if (!rv_ok) begin n_fail++; $display("FAIL rand_rvalid c%0d: i=%b d=%b expected side d=%b", c, i_rvalid, d_rvalid, out_d); end
        if (!(out_d && exp_we)) begin
          got = out_d ? d_rdata : i_rdata;
          n_checks++;
          if (got !== exp_data) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, got, exp_data); end
        end
        if (out_d) begin last_d = exp_data; seen_d = !exp_we; end
        else begin last_i = exp_data; seen_i = 1'b1; end
        out_act = 1'b0;
      end else begin
        n_checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
          n_fail++; $display("FAIL rand_extra_rvalid c%0d: i=%b d=%b expected 0 0", c, i_rvalid, d_rvalid);
        end
      end
      if (seen_i) begin
        n_checks++;
        if (i_rdata !== last_i) begin n_fail++; $display("FAIL rand_i_hold c%0d: got %h expected %h", c, i_rdata, last_i); end
      end
      if (seen_d) begin
        n_checks++;
        if (d_rdata !== last_d) begin n_fail++; $display("FAIL rand_d_hold c%0d: got %h expected %h", c, d_rdata, last_d); end
      end
      // arbitration rules
      want_i = 1'b0;
      want_d = 1'b0;
      if (!out_act) begin
        if (i_req && GUARD && s >= SMAX) want_i = 1'b1;
        else if (d_req) want_d = 1'b1;
        else if (i_req) want_i = 1'b1;
      end
      n_checks++;
      if ({gi, gd} !== {want_i, want_d}) begin
        n_fail++; $display("FAIL rand_grant c%0d: i_gnt=%b d_gnt=%b expected %b %b", c, gi, gd, want_i, want_d);
      end
      // consecutive data grants endured by a waiting fetch request
      if (gi || !i_req) s = 0;
      else if (gd && s < SMAX) s++;
      if (gi || gd) begin
        out_act = 1'b1; out_d = gd; age = 0;
        exp_addr  = gd ? d_addr : i_addr;
        exp_we    = gd ? d_we : 1'b0;
        exp_wdata = d_wdata;
        exp_wstrb = d_wstrb;
        exp_data  = mem_read(exp_addr);
        ack_delay = $urandom_range(0, 3);
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rand_gnt_cycle_req c%0d: mem_req=%b expected 0", c, mem_req); end
      end else if (out_act) begin
        age++;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we ||
            (exp_we && (mem_wdata !== exp_wdata || mem_wstrb !== exp_wstrb)) || age > 10) begin
          n_fail++;
          $display("FAIL rand_mem_bus c%0d: req=%b addr=%h we=%b wdata=%h wstrb=%b age=%0d expected 1 %h %b %h %b", c,
                   mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb, age, exp_addr, exp_we, exp_wdata, exp_wstrb);
        end
      end else begin
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rand_idle_req c%0d: mem_req=%b expected 0", c, mem_req); end
      end
      ack_prev = out_act && mem_ack;
      next_edge();
      if (gi) i_req = 1'b0;
      if (gd) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 99) < 50) begin
        i_req = 1'b1; i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_req && $urandom_range(0, 99) < 50) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_simultaneous();
    test_d_write_delayed();
    test_starvation();
    test_reset_mid_busy();
    test_spurious_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit reached");
  end

endmodule
